rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one resource among N_REQ requesters.
//   The winner is chosen by a lowest-set-bit priority encoder over a rotating mask.
//   A grant is held until the owner releases it, so a transaction is never preempted.
//   The block sits between the requesting masters and the shared resource's mux select.
//
// PARAMETERS
//   N_REQ    8                  number of requesters (any value >= 2; need not be a power of two)
//   IDX_W    $clog2(N_REQ)      width of the grant index
//   MAX_HOLD 16                 grant watchdog limit in cycles (used only with ARB_TIMEOUT_EN)
//
// PORTS
//   clk      in   1      single clock; all state updates on its rising edge
//   rst_n    in   1      asynchronous reset, active-low
//   req      in   N_REQ  request vector; bit i = requester i wants the resource
//   rel      in   1      release strobe from the current owner; valid only while busy=1
//   gnt      out  N_REQ  one-hot grant, registered
//   gnt_idx  out  IDX_W  binary index of the owner; meaningful only while busy=1
//   busy     out  1      a grant is active
//   timeout  out  1      1-cycle pulse when the watchdog forces a release
//
// BEHAVIOUR
//   - Reset (asynchronous, rst_n=0):
//     - Outputs: gnt=0, gnt_idx=0, busy=0, timeout=0.
//     - Internal: ptr=0, state=IDLE, hold counter=0.
//     - Asserting reset mid-grant drops gnt immediately, without waiting for a clock.
//   - FSM states: IDLE, BUSY.
//   - IDLE, req==0: remain in IDLE.
//   - IDLE, req!=0: go to BUSY.
//     - Winner = lowest set index of (req & mask(ptr)), where mask(ptr) has bits >= ptr set.
//     - If that masked vector is empty, winner = lowest set index of req.
//     - On the same edge: gnt=1<<winner, gnt_idx=winner, busy=1.
//   - Latency: req sampled at edge t produces gnt visible after edge t.
//   - BUSY:
//     - gnt and gnt_idx are frozen.
//     - Changes on req are ignored, including the owner dropping its own req.
//   - BUSY with rel=1: go to IDLE.
//     - gnt=0, busy=0.
//     - ptr = (gnt_idx==N_REQ-1) ? 0 : gnt_idx+1, i.e. wrap-around at the top index.
//   - Idle gap: at least one IDLE cycle separates consecutive grants.
//     - With requests pending continuously, grants arrive every (hold+1) cycles.
//   - rel while IDLE: ignored.
//   - ptr update: changes only on a release; arbitration never moves ptr.
//   - Width rule: winner and ptr are IDX_W bits wide.
//     - For non-power-of-two N_REQ, ptr never takes a value >= N_REQ.
//
// CONFIGURATION
//   - ARB_TIMEOUT_EN defined:
//     - A hold counter counts BUSY cycles.
//     - If MAX_HOLD cycles elapse without rel, the arbiter forces a release: same
//       transition and ptr update as rel, with timeout=1 for that one cycle.
//     - rel arriving on the limit cycle counts as a normal release; timeout stays 0.
//   - ARB_TIMEOUT_EN undefined:
//     - No counter is built; timeout is tied to 0.
//     - A grant lasts until rel.
//
// STRUCTURE
//   - arb_pkg holds:
//     - typedef arb_state_t {IDLE, BUSY};
//     - the helper function next_ptr(idx, n) for the wrap-around ptr update.
//   - Sub-module prio_enc #(N, W):
//     - Combinational lowest-set-bit encoder.
//     - Outputs idx[W-1:0] and valid (valid=|vec).
//     - Instantiated twice: once for the masked vector, once for the raw vector.
//
// TESTING
//   1. Reset, then req=8'b0000_0001 at edge 1:
//      -> gnt=8'h01, gnt_idx=0 and busy=1 after edge 1.
//   2. All req=8'hFF, each owner holds 2 cycles then pulses rel:
//      -> grant order 0,1,2,...,7,0 with exactly 1 idle cycle between grants.
//   3. Wrap-around: owner 7 releases while req=8'b1000_0100:
//      -> next grant goes to 2 (ptr=0), not to 7.
//   4. Owner 3 drops req without asserting rel, while others request:
//      -> gnt stays 8'h08 until rel.
//   5. rst_n pulled low mid-grant, between clock edges:
//      -> gnt=0 and busy=0 immediately.
//      -> After reset releases, the first grant again favours index 0.
//   6. ARB_TIMEOUT_EN, MAX_HOLD=16, owner never releases:
//      -> gnt drops after 16 BUSY cycles with a 1-cycle timeout pulse.
//      -> ptr advances to the next index.
//      -> Repeat with rel on cycle 16: release happens, timeout stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Shared state type and ptr wrap helper for the round-robin arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc.sv
// ============================================================================
// Module : prio_enc
// Combinational lowest-set-bit priority encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign valid = |vec;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Non-preemptive round-robin arbiter; ARB_TIMEOUT_EN adds a grant watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [N_REQ-1:0] masked_req;
    logic [IDX_W-1:0] masked_idx;
    logic             masked_valid;
    logic [IDX_W-1:0] raw_idx;
    logic             raw_valid;
    logic [IDX_W-1:0] win_idx;
    logic             force_rel;
    logic             do_release;

    always_comb begin
        masked_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            masked_req[i] = req[i] & (IDX_W'(i) >= ptr);
        end
    end

    prio_enc #(.N(N_REQ), .W(IDX_W)) u_enc_masked (
        .vec   (masked_req),
        .idx   (masked_idx),
        .valid (masked_valid)
    );

    prio_enc #(.N(N_REQ), .W(IDX_W)) u_enc_raw (
        .vec   (req),
        .idx   (raw_idx),
        .valid (raw_valid)
    );

    assign win_idx    = masked_valid ? masked_idx : raw_idx;
    assign do_release = (state == BUSY) && (rel || force_rel);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (raw_valid) begin
                    state_nxt = BUSY;
                    gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    idx_nxt   = win_idx;
                end
            end
            BUSY: begin
                if (rel || force_rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = IDX_W'(next_ptr(int'(gnt_idx), N_REQ));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            ptr     <= ptr_nxt;
        end
    end

    assign busy = (state == BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    // hold_cnt is the 1-based number of the BUSY cycle currently in progress.
    logic [HOLD_W-1:0] hold_cnt;
    logic              timeout_r;

    assign force_rel = (state == BUSY) && !rel && (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= force_rel;
            if (state == IDLE) begin
                hold_cnt <= HOLD_W'(1);
            end else if (!do_release) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
// Module : tb_rr_arbiter
// Directed and randomized self-checking bench for rr_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int MH = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic         rel   = 1'b0;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         busy;
    logic         timeout;

    rr_arbiter #(.N_REQ(N), .IDX_W(W), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: owner, rotating start point, elapsed hold cycles.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        m_to = 1'b0;
        if (!m_busy) begin
            if (req != '0) begin
                m_busy = 1'b1;
                m_idx  = pick(req, m_ptr);
                m_cnt  = 1;
            end
        end else if (rel) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % N;
        end else if (TO_EN && m_cnt == MH) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % N;
            m_to   = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_idx) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_busy) chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Asserted away from any clock edge so the asynchronous path is what clears gnt.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_to   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // Single requester, one-edge latency.
        req = 8'h01;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h01);
        chk("t1_busy", 32'(busy), 32'd1);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        req = '0;
        tick();

        // Full contention, each owner holds two cycles.
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            chk("t2_order", 32'(gnt_idx), 32'(g % 8));
            tick();
            rel = 1'b1;
            tick();
            rel = 1'b0;
            chk("t2_gap", 32'(busy), 32'd0);
        end

        // Wrap-around from owner 7.
        do_reset();
        req = 8'h80;
        tick();
        chk("t3_owner7", 32'(gnt_idx), 32'd7);
        req = 8'h84;
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk("t3_wrap", 32'(gnt), 32'h04);
        rel = 1'b1;
        tick();
        rel = 1'b0;

        // Owner drops its request without releasing.
        do_reset();
        req = 8'h08;
        tick();
        req = 8'hF7;
        repeat (5) begin
            tick();
            chk("t4_hold", 32'(gnt), 32'h08);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk("t4_next", 32'(gnt_idx), 32'd4);
        rel = 1'b1;
        tick();
        rel = 1'b0;

        // Reset in the middle of a grant.
        do_reset();
        req = 8'h10;
        tick();
        chk("t5_pre", 32'(gnt), 32'h10);
        do_reset();
        req = 8'h81;
        tick();
        chk("t5_after", 32'(gnt), 32'h01);
        rel = 1'b1;
        tick();
        rel = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Watchdog forces release after MH busy cycles.
        do_reset();
        req = 8'h03;
        tick();
        repeat (MH - 1) tick();
        chk("t6_busy_limit", 32'(busy), 32'd1);
        tick();
        chk("t6_timeout", 32'(timeout), 32'd1);
        chk("t6_drop", 32'(gnt), 32'd0);
        tick();
        chk("t6_ptr", 32'(gnt_idx), 32'd1);
        chk("t6_pulse", 32'(timeout), 32'd0);
        repeat (MH - 1) tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("t6_rel_at_limit", 32'(timeout), 32'd0);
        chk("t6_rel_drop", 32'(busy), 32'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        repeat (400) begin
            req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req = '0;
            rel = ($urandom_range(0, 2) == 0);
            tick();
        end
        rel = 1'b0;
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
